// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width
// and the default oversampling ratio.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int DATA_BITS      = 8;
   localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/rx_sync.sv
// Metastability flop chain for an asynchronous input.
// Resets to 1 so an idle serial line reads as idle.
module rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) ff <= '1;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/rx.sv
// UART 8N1 receiver sampling at mid-bit on an oversample strobe.
// Emits a one-cycle rx_valid per good frame, frame_err on a bad stop bit.
module rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxen,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   rx_state_t            state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [BW-1:0]        idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 valid_n, ferr_n;
   logic                 rxd_s;

   rx_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         frame_err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      data_n  = rx_data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      if (rxen) begin
         unique case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state_n = START;
                  cnt_n   = '0;
               end
            end
            START: begin
               // A start bit that is high again at mid-bit was a glitch
               if (cnt == CNT_HALF) begin
                  cnt_n   = '0;
                  idx_n   = '0;
                  state_n = rxd_s ? IDLE : DATA;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  sh_n  = {rxd_s, sh[DATA_BITS-1:1]};
                  cnt_n = '0;
                  idx_n = idx + 1'b1;
                  if (idx == IDX_LAST) state_n = STOP;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt_n = '0;
                  if (rxd_s) begin
                     data_n  = sh;
                     valid_n = 1'b1;
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = BREAK;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            BREAK: begin
               // Wait for the line to recover so a held-low line is one error
               if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_rx.sv
// Directed bench for the UART receiver with a byte scoreboard.
// Expected bytes are queued as frames are driven and matched on rx_valid.
module tb_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxen = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int n_tests = 0;
   int n_fail  = 0;

   int rxen_div = 1;
   bit rxen_on  = 1'b1;
   int bit_clk  = 16;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int ferr_cnt   = 0;
   int both_cnt   = 0;
   int busy_rises = 0;
   logic busy_q   = 1'b0;

   rx #(
      .OVERSAMPLE  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxen      (rxen),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   // Oversample strobe: one pulse every rxen_div clocks while enabled
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         rxen = (rxen_on && c == 0);
         c = (c + 1 >= rxen_div) ? 0 : c + 1;
      end
   end

   always @(negedge clk) begin
      if (rx_valid === 1'b1) got_q.push_back(rx_data);
      if (frame_err === 1'b1) ferr_cnt++;
      if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
      if (rx_busy === 1'b1 && busy_q !== 1'b1) busy_rises++;
      busy_q = rx_busy;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      idle(bit_clk);
   endtask

   // Line is left at the stop-bit level on return
   task automatic send_frame(input logic [7:0] b, input logic stop);
      if (stop) exp_q.push_back(b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_frames(input string tag);
      logic [7:0] g, e;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_data"}, 32'(g), 32'(e));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int f0, b0;
      logic [7:0] ab;

      rst = 1'b1;
      idle(3);
      check("rst_data",  32'(rx_data),   32'h00);
      check("rst_valid", 32'(rx_valid),  32'h0);
      check("rst_ferr",  32'(frame_err), 32'h0);
      check("rst_busy",  32'(rx_busy),   32'h0);
      rst = 1'b0;
      idle(20);

      // Plain frame
      f0 = ferr_cnt;
      send_frame(8'hA5, 1'b1);
      idle(2 * bit_clk);
      check_frames("a5");
      check("a5_ferr", 32'(ferr_cnt - f0), 32'h0);
      check("a5_busy", 32'(rx_busy), 32'h0);

      // Short low glitch
      f0 = ferr_cnt;
      b0 = busy_rises;
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(3 * bit_clk);
      check("glitch_frames", 32'(got_q.size()), 32'h0);
      check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
      check("glitch_busy_pulse", 32'(busy_rises - b0), 32'h1);
      check("glitch_busy_end", 32'(rx_busy), 32'h0);

      // Bad stop bit, line held low, then recovery
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      idle(40);
      check("ferr_pulse", 32'(ferr_cnt - f0), 32'h1);
      check("ferr_data_hold", 32'(rx_data), 32'hA5);
      check("ferr_no_frames", 32'(got_q.size()), 32'h0);
      rxd = 1'b1;
      idle(2 * bit_clk);
      send_frame(8'hC3, 1'b1);
      idle(2 * bit_clk);
      check_frames("c3");
      check("c3_ferr", 32'(ferr_cnt - f0), 32'h1);

      // Reset during data bit 4
      ab = 8'h12;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(ab[i]);
      rxd = ab[4];
      idle(bit_clk / 2);
      rst = 1'b1;
      idle(1);
      check("mid_rst_data",  32'(rx_data),   32'h00);
      check("mid_rst_valid", 32'(rx_valid),  32'h0);
      check("mid_rst_ferr",  32'(frame_err), 32'h0);
      check("mid_rst_busy",  32'(rx_busy),   32'h0);
      rst = 1'b0;
      rxd = 1'b1;
      idle(3 * bit_clk);
      check("aborted_frames", 32'(got_q.size()), 32'h0);
      send_frame(8'h55, 1'b1);
      idle(2 * bit_clk);
      check_frames("55");

      // Slow strobe with a frozen stretch in idle
      rxen_div = 3;
      bit_clk = 48;
      idle(10);
      b0 = busy_rises;
      rxen_on = 1'b0;
      idle(2);
      rxd = 1'b0;
      idle(100);
      check("freeze_busy", 32'(rx_busy), 32'h0);
      check("freeze_no_start", 32'(busy_rises - b0), 32'h0);
      rxd = 1'b1;
      idle(5);
      rxen_on = 1'b1;
      idle(2 * bit_clk);
      check("freeze_frames", 32'(got_q.size()), 32'h0);
      send_frame(8'hFF, 1'b1);
      idle(2 * bit_clk);
      check_frames("ff_slow");
      check("ff_slow_hold", 32'(rx_data), 32'hFF);

      // Back-to-back frames with a single stop bit
      rxen_div = 1;
      bit_clk = 16;
      idle(40);
      f0 = ferr_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(2 * bit_clk);
      check_frames("b2b");
      check("b2b_ferr", 32'(ferr_cnt - f0), 32'h0);
      check("b2b_busy", 32'(rx_busy), 32'h0);

      check("never_both", 32'(both_cnt), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx.md
Name: rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter in the UART calculator project.
- Deserialises one 8N1 frame from the asynchronous `rxd` line: start bit low, 8 data bits LSB first, stop bit high.
- Samples at mid-bit using an oversampling enable strobe `rxen`, supplied by the shared baud generator at OVERSAMPLE × baud rate.
- Delivers each received byte as a one-cycle `rx_valid` pulse to the calculator front end.

Parameters:
- OVERSAMPLE, 16, number of `rxen` ticks per bit period; must be even and ≥ 4.
- SYNC_STAGES, 2, number of metastability flops on `rxd`; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rxen  input  1  oversample tick; one-cycle strobe at OVERSAMPLE × baud.
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; `rx_data` is new in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; sync flops = 1; tick counter = 0; bit index = 0; shift register = 0x00.
  - rx_data = 0x00; rx_valid = 0; frame_err = 0; rx_busy = 0.
  - Reset mid-frame discards the partial frame and produces no pulse.
- All FSM logic uses `rxd_s`, the output of the SYNC_STAGES flop chain; raw `rxd` is used nowhere else.
- The FSM advances only in cycles where rxen=1. With rxen=0, state and counters hold.
- IDLE:
  - On rxen=1 and rxd_s=0: go to START, cnt = 0.
- START:
  - Each tick: cnt++.
  - On the tick where cnt reaches OVERSAMPLE/2−1 (mid start bit), check rxd_s:
    - rxd_s=0: go to DATA, cnt = 0, bit index = 0.
    - rxd_s=1: treat as a glitch; go to IDLE with no output.
- DATA:
  - Each tick: cnt++.
  - On the tick where cnt = OVERSAMPLE−1:
    - Sample rxd_s into the shift register: shift right, new bit into [7].
    - cnt = 0; bit index++.
    - After the 8th sample, go to STOP.
- STOP:
  - On the tick where cnt = OVERSAMPLE−1, sample rxd_s:
    - 1: rx_data ← shift register; rx_valid = 1 for exactly the next clk cycle; go to IDLE.
    - 0: frame_err = 1 for exactly one cycle; rx_data unchanged; go to BREAK.
- BREAK:
  - Go to IDLE on the first rxen tick with rxd_s=1. This prevents a held-low line from producing repeated false frames.
- Output timing:
  - rx_valid and frame_err are registered. They assert on the clk edge following the deciding tick.
  - They are never asserted together.
- Back-to-back frames: a new start edge is accepted on the first IDLE tick after the stop sample, so a 1-bit stop period is sufficient.
- No flow control; no overrun flag. The consumer must take `rx_data` on `rx_valid`; `rx_data` holds until the next good frame.
- The tick counter is $clog2(OVERSAMPLE) bits wide. It wraps only through the explicit clears above.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams: IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3, BREAK=3'd4;
  - DATA_BITS=8;
  - default OVERSAMPLE.
- Sub-module rx_sync: a parameterised SYNC_STAGES flop chain with synchronous reset to 1. It is shared with the transmitter-side loopback bench.

Test Plan:
- OVERSAMPLE=16, rxen=1 every clk, 16 clk/bit; drive frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) → one rx_valid pulse, rx_data=0xA5, frame_err never high, rx_busy low after the pulse.
- Same setup, rxd low for 4 clk then high → no rx_valid, no frame_err; rx_busy pulses briefly then returns to 0 (glitch rejection).
- Frame 0x3C with stop bit driven 0, line held low 40 clk, then high, then a valid frame 0xC3 → frame_err one cycle, rx_data keeps its prior value, no false frames while low, then rx_valid with rx_data=0xC3.
- rst asserted for 1 clk during data bit 4 of frame 0x12, then full frame 0x55 → all outputs 0 after reset, no pulse for the aborted frame, then rx_valid with rx_data=0x55.
- rxen pulsed every 3rd clk, 48 clk/bit; frame 0xFF, with rxen forced low for 100 clk mid-idle → rx_data=0xFF; FSM frozen while rxen=0.
- Back-to-back frames 0x00 then 0xFF with exactly 1-bit stop → two rx_valid pulses, rx_data=0x00 then 0xFF, no frame_err.
